// File: rtl/btn_evt_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT2,
    PRESSED2,
    LONG
  } state_t;

  // Defaults assume a 100 MHz clk.
  localparam int DEF_LONG_CYCLES   = 100_000_000;
  localparam int DEF_DCLICK_CYCLES = 30_000_000;
  localparam int DEF_REPEAT_CYCLES = 20_000_000;
  localparam int DEF_CNT_W         = 27;

endpackage

// File: rtl/edge_detect.sv
// Registered one-cycle delay of d with combinational rise/fall strobes.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  // A reset value of 1 hides a level that is already high when reset lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= RST_VAL;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into click / double click / long press pulses.
// Optional auto-repeat while held long is built when BTN_REPEAT_EN is defined.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic repeat_o,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

  if ((LONG_CYCLES < 1) || (DCLICK_CYCLES < 1) || (REPEAT_CYCLES < 1) ||
      (longint'(LONG_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(DCLICK_CYCLES) >= (longint'(1) << CNT_W)) ||
      (longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_cfg_err
    $error("button_event_decoder: cycle parameters must be >= 1 and fit in CNT_W");
  end

  logic rise;
  logic fall;

  edge_detect #(
    .RST_VAL(1'b1)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .d   (clean),
    .rise(rise),
    .fall(fall)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               click_q, click_d;
  logic               dclick_q, dclick_d;
  logic               long_q, long_d;

  // Edges win over timeouts: a fall beats the long threshold, a rise beats
  // the double-click window closing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESSED2;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) begin
          state_d  = IDLE;
          cnt_d    = '0;
          dclick_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;

  // rep_cnt sits at 0 outside LONG, so it starts counting on the long_press edge.
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if ((state_q == LONG) && !fall) begin
      if (rep_cnt_q == REPEAT_LAST) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign click      = click_q;
  assign dclick     = dclick_q;
  assign long_press = long_q;
  assign busy       = (state_q != IDLE);

endmodule
